// File: rtl/serial_add_sub_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, shared with the combinational ripple-carry adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one full-adder cell, WIDTH cycles per operation,
// valid/ready handshakes on both sides.
module serial_add_sub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    import serial_add_sub_pkg::*;

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH:0]   result_ext;

    full_adder u_full_adder (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign in_ready = (state == StIdle) & ~rst;

    // New sum bit enters at the MSB; widened so WIDTH=1 needs no empty slice.
    assign result_ext = {fa_s, result};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + ~cin, so cout=1 means no borrow.
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        cnt   <= '0;
                        state <= StRun;
                    end
                end
                StRun: begin
                    carry  <= fa_cout;
                    result <= result_ext[WIDTH:1];
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LastBit) begin
                        state     <= StDone;
                        out_valid <= 1'b1;
                        cout      <= fa_cout;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
